// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: arbitration modes,
// port identifiers and command-register field widths.
package dmem_arbiter_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam int CMD_ID_W = 1;
    localparam int CMD_WE_W = 1;

    // Index of the granted port from a one-hot 2-bit grant vector
    function automatic logic [CMD_ID_W-1:0] gnt_to_id(input logic [1:0] gnt);
        return gnt[1] ? PORT_DBG : PORT_CPU;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of requester handshakes and memory-side signals for dmem_arbiter.
// The slave modport is the arbiter; the master modport is the environment
// (requesters plus the external data memory).
interface dmem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              i_req_0;
    logic              i_req_1;
    logic              i_we_0;
    logic              i_we_1;
    logic [ADDR_W-1:0] i_addr_0;
    logic [ADDR_W-1:0] i_addr_1;
    logic [DATA_W-1:0] i_wdata_0;
    logic [DATA_W-1:0] i_wdata_1;
    logic              o_gnt_0;
    logic              o_gnt_1;
    logic              o_done_0;
    logic              o_done_1;
    logic [DATA_W-1:0] o_rdata;
    logic              o_err;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_data;
    logic              o_mem_we;
    logic [DATA_W-1:0] i_mem_data;

    modport slave (
        input  i_req_0, i_req_1, i_we_0, i_we_1, i_addr_0, i_addr_1,
               i_wdata_0, i_wdata_1, i_mem_data,
        output o_gnt_0, o_gnt_1, o_done_0, o_done_1, o_rdata, o_err,
               o_mem_addr, o_mem_data, o_mem_we
    );

    modport master (
        output i_req_0, i_req_1, i_we_0, i_we_1, i_addr_0, i_addr_1,
               i_wdata_0, i_wdata_1, i_mem_data,
        input  o_gnt_0, o_gnt_1, o_done_0, o_done_1, o_rdata, o_err,
               o_mem_addr, o_mem_data, o_mem_we
    );

endinterface

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-way arbiter. Grant is combinational from the requests and the
// pointer; in round-robin mode the pointer flips to the port that did not
// win after every grant, in fixed mode port 0 always wins.
module rr_arbiter2
    import dmem_arbiter_pkg::*;
#(
    parameter int ARB_MODE = ARB_RR
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic       ptr_r;
    logic [1:0] gnt_s;

    // Grant decode: lone requester always wins, contention resolved by mode
    always_comb begin
        gnt_s = 2'b00;
        case (req)
            2'b01:   gnt_s = 2'b01;
            2'b10:   gnt_s = 2'b10;
            2'b11: begin
                if (ARB_MODE == ARB_FIXED) begin
                    gnt_s = 2'b01;
                end else if (ptr_r == PORT_CPU) begin
                    gnt_s = 2'b01;
                end else begin
                    gnt_s = 2'b10;
                end
            end
            default: gnt_s = 2'b00;
        endcase
    end

    assign gnt = gnt_s;

    // Pointer moves to the non-granted port after each grant (round-robin only)
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr_r <= PORT_CPU;
        end else if ((ARB_MODE == ARB_RR) && (gnt_s != 2'b00)) begin
            ptr_r <= ~gnt_to_id(gnt_s);
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port data memory.
// Pipeline: A (grant + capture), M (drive memory), R (done/rdata/err).
// Out-of-range addresses never reach the memory as writes and read back 0.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MEM_DEPTH = 128,
    parameter int ARB_MODE  = ARB_RR
) (
    input  logic          i_clk,
    input  logic          i_rst,
    dmem_arbiter_if.slave bus
);

    logic [1:0]          req_s;
    logic [1:0]          gnt_s;
    logic                accept_s;
    logic                we_s;
    logic [ADDR_W-1:0]   addr_s;
    logic [DATA_W-1:0]   wdata_s;

    logic                cmd_valid_r;
    logic [CMD_ID_W-1:0] cmd_id_r;
    logic [CMD_WE_W-1:0] cmd_we_r;
    logic                cmd_ok_r;
    logic [ADDR_W-1:0]   cmd_addr_r;
    logic [DATA_W-1:0]   cmd_wdata_r;
    logic                mem_we_r;

    logic                done_0_r;
    logic                done_1_r;
    logic                err_r;
    logic [DATA_W-1:0]   rdata_r;

    // Range check against the physical memory depth
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return a < ADDR_W'(MEM_DEPTH);
    endfunction

    assign req_s = {bus.i_req_1, bus.i_req_0};

    rr_arbiter2 #(.ARB_MODE(ARB_MODE)) u_arb (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .req   (req_s),
        .gnt   (gnt_s)
    );

    assign accept_s    = |gnt_s;
    assign bus.o_gnt_0 = gnt_s[0];
    assign bus.o_gnt_1 = gnt_s[1];

    // Mux the granted port's command fields
    always_comb begin
        we_s    = 1'b0;
        addr_s  = {ADDR_W{1'b0}};
        wdata_s = {DATA_W{1'b0}};
        if (gnt_s[1]) begin
            we_s    = bus.i_we_1;
            addr_s  = bus.i_addr_1;
            wdata_s = bus.i_wdata_1;
        end else begin
            we_s    = bus.i_we_0;
            addr_s  = bus.i_addr_0;
            wdata_s = bus.i_wdata_0;
        end
    end

    // Command stage: capture the accepted request; zeros when idle so the memory bus rests at 0
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cmd_valid_r <= 1'b0;
            cmd_id_r    <= PORT_CPU;
            cmd_we_r    <= 1'b0;
            cmd_ok_r    <= 1'b0;
            cmd_addr_r  <= {ADDR_W{1'b0}};
            cmd_wdata_r <= {DATA_W{1'b0}};
            mem_we_r    <= 1'b0;
        end else if (accept_s) begin
            cmd_valid_r <= 1'b1;
            cmd_id_r    <= gnt_to_id(gnt_s);
            cmd_we_r    <= we_s;
            cmd_ok_r    <= addr_ok(addr_s);
            cmd_addr_r  <= addr_s;
            cmd_wdata_r <= we_s ? wdata_s : {DATA_W{1'b0}};
            mem_we_r    <= we_s & addr_ok(addr_s);
        end else begin
            cmd_valid_r <= 1'b0;
            cmd_id_r    <= PORT_CPU;
            cmd_we_r    <= 1'b0;
            cmd_ok_r    <= 1'b0;
            cmd_addr_r  <= {ADDR_W{1'b0}};
            cmd_wdata_r <= {DATA_W{1'b0}};
            mem_we_r    <= 1'b0;
        end
    end

    assign bus.o_mem_addr = cmd_addr_r;
    assign bus.o_mem_data = cmd_wdata_r;
    assign bus.o_mem_we   = mem_we_r;

    // Response stage: one-cycle done pulse, read data or 0, error flag for bad addresses
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            done_0_r <= 1'b0;
            done_1_r <= 1'b0;
            err_r    <= 1'b0;
            rdata_r  <= {DATA_W{1'b0}};
        end else begin
            done_0_r <= cmd_valid_r & (cmd_id_r == PORT_CPU);
            done_1_r <= cmd_valid_r & (cmd_id_r == PORT_DBG);
            err_r    <= cmd_valid_r & ~cmd_ok_r;
            rdata_r  <= (cmd_valid_r & ~cmd_we_r & cmd_ok_r) ? bus.i_mem_data : {DATA_W{1'b0}};
        end
    end

    assign bus.o_done_0 = done_0_r;
    assign bus.o_done_1 = done_1_r;
    assign bus.o_err    = err_r;
    assign bus.o_rdata  = rdata_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a cycle table on a round-robin instance,
// plus hand sequences for fixed priority and reset during a write.
module tb_dmem_arbiter;

    logic clk;
    logic rst;

    int total;
    int bad;

    dmem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus_a ();
    dmem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus_f ();

    dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_DEPTH(128), .ARB_MODE(1)) dut_a (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_a.slave)
    );

    dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_DEPTH(128), .ARB_MODE(0)) dut_f (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_f.slave)
    );

    // Memory models for each instance
    logic [31:0] mem_a [128];
    logic [31:0] mem_f [128];

    assign bus_a.i_mem_data = (bus_a.o_mem_addr < 32'd128) ? mem_a[bus_a.o_mem_addr[6:0]] : 32'd0;
    assign bus_f.i_mem_data = (bus_f.o_mem_addr < 32'd128) ? mem_f[bus_f.o_mem_addr[6:0]] : 32'd0;

    always @(posedge clk) begin
        if (bus_a.o_mem_we) mem_a[bus_a.o_mem_addr[6:0]] <= bus_a.o_mem_data;
        if (bus_f.o_mem_we) mem_f[bus_f.o_mem_addr[6:0]] <= bus_f.o_mem_data;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r0, r1, w0, w1;
        logic [31:0] a0, a1, d0;
        logic        g0, g1, dn0, dn1, err, mwe;
        logic [31:0] rd;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic r0, input logic r1, input logic w0, input logic w1,
                                input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] d0,
                                input logic g0, input logic g1, input logic dn0, input logic dn1,
                                input logic err, input logic mwe, input logic [31:0] rd);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1;
        v.a0 = a0; v.a1 = a1; v.d0 = d0;
        v.g0 = g0; v.g1 = g1; v.dn0 = dn0; v.dn1 = dn1;
        v.err = err; v.mwe = mwe; v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle_a();
        bus_a.i_req_0 = 1'b0; bus_a.i_req_1 = 1'b0;
        bus_a.i_we_0 = 1'b0;  bus_a.i_we_1 = 1'b0;
        bus_a.i_addr_0 = 32'd0; bus_a.i_addr_1 = 32'd0;
        bus_a.i_wdata_0 = 32'd0; bus_a.i_wdata_1 = 32'd0;
    endtask

    task automatic idle_f();
        bus_f.i_req_0 = 1'b0; bus_f.i_req_1 = 1'b0;
        bus_f.i_we_0 = 1'b0;  bus_f.i_we_1 = 1'b0;
        bus_f.i_addr_0 = 32'd0; bus_f.i_addr_1 = 32'd0;
        bus_f.i_wdata_0 = 32'd0; bus_f.i_wdata_1 = 32'd0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 128; i++) begin
            mem_a[i] = 32'd0;
            mem_f[i] = 32'd0;
        end
        idle_a();
        idle_f();

        // Port 1 writes use a fixed data word
        bus_a.i_wdata_1 = 32'h0000_1234;

        //        r0   r1   w0   w1   a0      a1     d0            g0   g1   dn0  dn1  err  mwe  rd
        // write 5, read 5
        vecs[0]  = mk(1'b1,1'b0,1'b1,1'b0,32'd5,  32'd0,32'hDEADBEEF,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,32'd0);
        vecs[1]  = mk(1'b1,1'b0,1'b0,1'b0,32'd5,  32'd0,32'd0,       1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,32'd0);
        vecs[2]  = mk(1'b0,1'b0,1'b0,1'b0,32'd0,  32'd0,32'd0,       1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'd0);
        vecs[3]  = mk(1'b0,1'b0,1'b0,1'b0,32'd0,  32'd0,32'd0,       1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'hDEADBEEF);
        // lone port 1 read (pointer back to port 0), then contention for 6 cycles
        vecs[4]  = mk(1'b0,1'b1,1'b0,1'b0,32'd0,  32'd1,32'd0,       1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'd0);
        vecs[5]  = mk(1'b1,1'b1,1'b0,1'b0,32'd5,  32'd6,32'd0,       1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,32'd0);
        vecs[6]  = mk(1'b1,1'b1,1'b0,1'b0,32'd5,  32'd6,32'd0,       1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,32'd0);
        vecs[7]  = mk(1'b1,1'b1,1'b0,1'b0,32'd5,  32'd6,32'd0,       1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,32'hDEADBEEF);
        vecs[8]  = mk(1'b1,1'b1,1'b0,1'b0,32'd5,  32'd6,32'd0,       1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,32'd0);
        vecs[9]  = mk(1'b1,1'b1,1'b0,1'b0,32'd5,  32'd6,32'd0,       1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,32'hDEADBEEF);
        vecs[10] = mk(1'b1,1'b1,1'b0,1'b0,32'd5,  32'd6,32'd0,       1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,32'd0);
        vecs[11] = mk(1'b0,1'b0,1'b0,1'b0,32'd0,  32'd0,32'd0,       1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'hDEADBEEF);
        vecs[12] = mk(1'b0,1'b0,1'b0,1'b0,32'd0,  32'd0,32'd0,       1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,32'd0);
        // out-of-range write and read at 200
        vecs[13] = mk(1'b1,1'b0,1'b1,1'b0,32'd200,32'd0,32'h00000055,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,32'd0);
        vecs[14] = mk(1'b1,1'b0,1'b0,1'b0,32'd200,32'd0,32'd0,       1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,32'd0);
        vecs[15] = mk(1'b0,1'b0,1'b0,1'b0,32'd0,  32'd0,32'd0,       1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,32'd0);
        vecs[16] = mk(1'b0,1'b0,1'b0,1'b0,32'd0,  32'd0,32'd0,       1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,32'd0);
        // port 1 write 9, port 0 reads 9 the next cycle
        vecs[17] = mk(1'b0,1'b1,1'b0,1'b1,32'd0,  32'd9,32'd0,       1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'd0);
        vecs[18] = mk(1'b1,1'b0,1'b0,1'b0,32'd9,  32'd0,32'd0,       1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,32'd0);
        vecs[19] = mk(1'b0,1'b0,1'b0,1'b0,32'd0,  32'd0,32'd0,       1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,32'd0);
        vecs[20] = mk(1'b0,1'b0,1'b0,1'b0,32'd0,  32'd0,32'd0,       1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h00001234);

        // Reset: outputs must be zero while held
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst.done0", {31'd0, bus_a.o_done_0}, 32'd0);
        chk("rst.done1", {31'd0, bus_a.o_done_1}, 32'd0);
        chk("rst.err",   {31'd0, bus_a.o_err},    32'd0);
        chk("rst.memwe", {31'd0, bus_a.o_mem_we}, 32'd0);
        chk("rst.maddr", bus_a.o_mem_addr,        32'd0);
        chk("rst.rdata", bus_a.o_rdata,           32'd0);
        next_cycle();
        rst = 1'b0;

        // Table-driven sequence on the round-robin instance
        for (int i = 0; i < NV; i++) begin
            bus_a.i_req_0   = vecs[i].r0;
            bus_a.i_req_1   = vecs[i].r1;
            bus_a.i_we_0    = vecs[i].w0;
            bus_a.i_we_1    = vecs[i].w1;
            bus_a.i_addr_0  = vecs[i].a0;
            bus_a.i_addr_1  = vecs[i].a1;
            bus_a.i_wdata_0 = vecs[i].d0;
            @(negedge clk);
            chk($sformatf("v%0d.gnt0", i),  {31'd0, bus_a.o_gnt_0},  {31'd0, vecs[i].g0});
            chk($sformatf("v%0d.gnt1", i),  {31'd0, bus_a.o_gnt_1},  {31'd0, vecs[i].g1});
            chk($sformatf("v%0d.done0", i), {31'd0, bus_a.o_done_0}, {31'd0, vecs[i].dn0});
            chk($sformatf("v%0d.done1", i), {31'd0, bus_a.o_done_1}, {31'd0, vecs[i].dn1});
            chk($sformatf("v%0d.err", i),   {31'd0, bus_a.o_err},    {31'd0, vecs[i].err});
            chk($sformatf("v%0d.memwe", i), {31'd0, bus_a.o_mem_we}, {31'd0, vecs[i].mwe});
            chk($sformatf("v%0d.rdata", i), bus_a.o_rdata,           vecs[i].rd);
            next_cycle();
        end
        idle_a();

        // Fixed priority: port 0 wins 4 contended cycles, port 1 gets the first free one
        bus_f.i_req_0 = 1'b1; bus_f.i_addr_0 = 32'd2;
        bus_f.i_req_1 = 1'b1; bus_f.i_addr_1 = 32'd3;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("fix%0d.gnt0", c), {31'd0, bus_f.o_gnt_0}, 32'd1);
            chk($sformatf("fix%0d.gnt1", c), {31'd0, bus_f.o_gnt_1}, 32'd0);
            next_cycle();
        end
        bus_f.i_req_0 = 1'b0;
        @(negedge clk);
        chk("fix.drop.gnt0",  {31'd0, bus_f.o_gnt_0},  32'd0);
        chk("fix.drop.gnt1",  {31'd0, bus_f.o_gnt_1},  32'd1);
        chk("fix.drop.done0", {31'd0, bus_f.o_done_0}, 32'd1);
        next_cycle();
        idle_f();

        // Reset during the memory stage of a write to addr 3
        bus_a.i_req_0 = 1'b1; bus_a.i_we_0 = 1'b1;
        bus_a.i_addr_0 = 32'd3; bus_a.i_wdata_0 = 32'hAAAA5555;
        @(negedge clk);
        chk("rw.gnt0", {31'd0, bus_a.o_gnt_0}, 32'd1);
        next_cycle();
        idle_a();
        chk("rw.memwe.pre", {31'd0, bus_a.o_mem_we}, 32'd1);
        chk("rw.maddr.pre", bus_a.o_mem_addr,        32'd3);
        rst = 1'b1;
        #1;
        chk("rw.memwe.rst", {31'd0, bus_a.o_mem_we}, 32'd0);
        chk("rw.maddr.rst", bus_a.o_mem_addr,        32'd0);
        next_cycle();
        chk("rw.done0.rst", {31'd0, bus_a.o_done_0}, 32'd0);
        rst = 1'b0;
        bus_a.i_req_0 = 1'b1; bus_a.i_addr_0 = 32'd3;
        @(negedge clk);
        chk("rr.gnt0",  {31'd0, bus_a.o_gnt_0},  32'd1);
        chk("rr.done0", {31'd0, bus_a.o_done_0}, 32'd0);
        next_cycle();
        idle_a();
        @(negedge clk);
        chk("rr.done0.m", {31'd0, bus_a.o_done_0}, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("rr.done0.r", {31'd0, bus_a.o_done_0}, 32'd1);
        chk("rr.rdata",   bus_a.o_rdata,           32'd0);
        chk("rr.err",     {31'd0, bus_a.o_err},    32'd0);
        next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
